serial_digit_adder: RTL
=======================

# serial_digit_adder

Parametrised digit-serial adder/subtractor: the next generation of the bit-serial adder with valid/last framing. It consumes operands LSD-first, `DIGIT_W` bits per valid beat, and supports add or subtract per word. Output digits are registered and carry the same vld/last framing. At word end it reports carry/no-borrow, signed overflow, digit count and a length error. It sits between serial operand sources and downstream serial consumers in the datapath.

## Interface
- `DIGIT_W`, 4, bits per digit; ≥1.
- `MAX_DIGITS`, 16, maximum digits per word; ≥1. `CNT_W = $clog2(MAX_DIGITS+1)`.

- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `vld`  in  1  input digit valid.
- `a`  in  DIGIT_W  operand A digit, LSD first.
- `b`  in  DIGIT_W  operand B digit, LSD first.
- `sub`  in  1  mode; sampled only on a word's first valid digit. 1 = A−B.
- `last`  in  1  final digit of word; honoured only when `vld`=1.
- `out_vld`  out  1  registered output digit valid.
- `sum`  out  DIGIT_W  result digit.
- `out_last`  out  1  final result digit; word-level flags below are valid only while `out_vld && out_last`.
- `carry_out`  out  1  final carry (add: carry; sub: 1 = no borrow).
- `ovf`  out  1  two's-complement overflow of the word.
- `out_len`  out  CNT_W  digits in word, saturated at MAX_DIGITS.
- `out_err`  out  1  word exceeded MAX_DIGITS.

## Operation
- State: `FIRST` (awaiting first digit of a word), `MID` (inside a word). Reset → `FIRST`.
- `FIRST` + `vld`: latch `sub` into `mode`. Carry-in = `sub`, B operand = `sub ? ~b : b`. Digit count = 1.
  - If `last`=1: stay in `FIRST` (single-digit word).
  - Else: go to `MID`.
- `MID` + `vld`: carry-in = stored carry, B = `mode ? ~b : b`. Count increments, saturating at MAX_DIGITS; `err` is set if a digit arrives while count == MAX_DIGITS.
  - `last`=1 → `FIRST`.
- `vld`=0: no state, carry, count, err or mode change; `last`/`sub` ignored.
- Digit arithmetic: `{c, s} = a + B + cin`, DIGIT_W+1 bits; stored carry ← `c`.
- On the last digit:
  - `carry_out` = `c`.
  - `ovf` = carry into the MSB XOR carry out of the MSB.
  - `out_len` = count (including this digit, saturated).
  - `out_err` = err (including this digit).
  - carry, count and err clear for the next word.
- `out_last`, `carry_out`, `ovf`, `out_len`, `out_err` are 0 on every output beat other than a last beat.

## Timing
- Latency: 1 cycle. Digit accepted at edge N appears on `sum`/`out_vld` after edge N, valid during cycle N+1.
- No backpressure; one digit per cycle sustained; back-to-back words with no gap are supported. The cycle after `last`, the next word starts in `FIRST`.
- `out_vld`=0 cycles: `sum` and all flags are 0.
- Reset, including mid-word:
  - State → `FIRST`; carry, count, err, mode → 0.
  - All outputs read 0 in the cycle after the reset edge.
  - Any partial word is discarded; no `out_last` is emitted for it.
  - `rst` has priority over `vld` in the same cycle.
- Reset values: `out_vld`, `sum`, `out_last`, `carry_out`, `ovf`, `out_len`, `out_err` = 0.

## Configuration
- `SERIAL_DIGIT_ADDER_OVF_EN` defined: `ovf` is computed as above.
- Not defined: the MSB-carry tap and overflow register are omitted; `ovf` is tied to 0. All other behaviour is identical.

## Test plan
Default parameters (`DIGIT_W`=4) unless noted.
- Add 0x0FF + 0x001: A digits F,F,0; B digits 1,0,0; `last` on 3rd → `sum` 0,0,1, `carry_out`=0, `ovf`=0, `out_len`=3.
- Subtract 0x10 − 0x01 (`sub`=1 on first digit only): A digits 0,1; B digits 1,0 → `sum` F,0, `carry_out`=1. Then 0x01 − 0x10 → `sum` 1,F, `carry_out`=0.
- Overflow (macro defined): 0x7F + 0x01 → `sum` F→0,8, `ovf`=1. Macro undefined → `ovf`=0.
- Gaps: add 0x0FF + 0x001 with `vld`=0 cycles between digits, and `last`=1 asserted during those gaps → same result as the first test; no spurious `out_vld`/`out_last`.
- Reset mid-word: apply `rst` after 2 digits of F,F + 1,0, then send a new word 0x12 + 0x34 → `sum` 6,4, carry clean, `out_len`=2.
- `MAX_DIGITS`=4, 5-digit word of zeros → `out_err`=1, `out_len`=4 on the last beat; the following 2-digit word → `out_err`=0.

Source files
------------

// File: rtl/serial_digit_adder.sv
// Digit-serial add/subtract, LSD first, vld/last framing; optional overflow via SERIAL_DIGIT_ADDER_OVF_EN.
// Latency: 1 cycle, all outputs registered.
// Backpressure: none; one digit per cycle, back-to-back words supported.
module serial_digit_adder #(
    parameter int DIGIT_W    = 4,
    parameter int MAX_DIGITS = 16,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               vld_i,
    input  logic [DIGIT_W-1:0] a_i,
    input  logic [DIGIT_W-1:0] b_i,
    input  logic               sub_i,
    input  logic               last_i,
    output logic               out_vld_o,
    output logic [DIGIT_W-1:0] sum_o,
    output logic               out_last_o,
    output logic               carry_out_o,
    output logic               ovf_o,
    output logic [CNT_W-1:0]   out_len_o,
    output logic               out_err_o
);

    typedef enum logic {FIRST, MID} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

    state_t             state_q;
    logic               mode_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;

    logic               out_vld_q;
    logic [DIGIT_W-1:0] sum_q;
    logic               out_last_q;
    logic               carry_out_q;
    logic [CNT_W-1:0]   out_len_q;
    logic               out_err_q;

    logic               first;
    logic               mode_d;
    logic               cin;
    logic [DIGIT_W-1:0] bb;
    logic [DIGIT_W-1:0] sum_d;
    logic               carry_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               err_d;
    logic               end_beat;

    always_comb begin
        first    = (state_q == FIRST);
        mode_d   = first ? sub_i : mode_q;
        cin      = first ? sub_i : carry_q;
        bb       = mode_d ? ~b_i : b_i;
        {carry_d, sum_d} = {1'b0, a_i} + {1'b0, bb} + {{DIGIT_W{1'b0}}, cin};
        cnt_d    = CNT_W'(1);
        err_d    = 1'b0;
        if (!first) begin
            cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CNT_W'(1);
            err_d = err_q | (cnt_q == MAX_CNT);
        end
        end_beat = vld_i & last_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= FIRST;
            mode_q      <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_vld_q   <= 1'b0;
            sum_q       <= '0;
            out_last_q  <= 1'b0;
            carry_out_q <= 1'b0;
            out_len_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            out_vld_q   <= vld_i;
            sum_q       <= vld_i ? sum_d : '0;
            out_last_q  <= end_beat;
            carry_out_q <= end_beat & carry_d;
            out_len_q   <= end_beat ? cnt_d : '0;
            out_err_q   <= end_beat & err_d;
            if (vld_i) begin
                mode_q <= mode_d;
                if (last_i) begin
                    state_q <= FIRST;
                    carry_q <= 1'b0;
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                end else begin
                    state_q <= MID;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_d;
                    err_q   <= err_d;
                end
            end
        end
    end

`ifdef SERIAL_DIGIT_ADDER_OVF_EN
    logic msb_cin;
    logic ovf_q;

    // Carry into the MSB recovered from the MSB's own sum bit and operands.
    assign msb_cin = sum_d[DIGIT_W-1] ^ a_i[DIGIT_W-1] ^ bb[DIGIT_W-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= end_beat & (msb_cin ^ carry_d);
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

    assign out_vld_o   = out_vld_q;
    assign sum_o       = sum_q;
    assign out_last_o  = out_last_q;
    assign carry_out_o = carry_out_q;
    assign out_len_o   = out_len_q;
    assign out_err_o   = out_err_q;

endmodule
